// File: rtl/regfile_dump_streamer.sv
// rtl/regfile_dump_streamer.sv - walks FIRST_REG..LAST_REG over a regfile read port and streams 5-byte records.
// Optional trailing XOR checksum byte when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_streamer #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 29
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        start,
  output logic        busy,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_SEND,
    S_DONE
`ifdef REGDUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_idx;
  logic [2:0]  r_cnt;
  logic [31:0] r_hold;
  logic [7:0]  w_byte;
  logic        w_hs;
  logic        w_last_byte;
  logic        w_last_reg;
`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  assign w_hs        = out_valid & out_ready;
  assign w_last_byte = (r_cnt == 3'd4);
  assign w_last_reg  = (r_idx == LAST_IDX);
  assign busy        = (r_state != S_IDLE);
  assign rd_addr     = r_idx;

  // Record layout: index byte, then the captured word MSB first.
  always_comb begin
    case (r_cnt)
      3'd0:    w_byte = {3'b000, r_idx};
      3'd1:    w_byte = r_hold[31:24];
      3'd2:    w_byte = r_hold[23:16];
      3'd3:    w_byte = r_hold[15:8];
      default: w_byte = r_hold[7:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_ADDR;
      S_ADDR: w_next = S_LOAD;
      S_LOAD: w_next = S_SEND;
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = w_byte;
`ifndef REGDUMP_CHECKSUM_EN
        out_last  = w_last_byte & w_last_reg;
`endif
        if (w_hs && w_last_byte) begin
          if (w_last_reg) begin
`ifdef REGDUMP_CHECKSUM_EN
            w_next = S_CSUM;
`else
            w_next = S_DONE;
`endif
          end else begin
            w_next = S_ADDR;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = r_csum;
        out_last  = 1'b1;
        if (w_hs) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_idx  <= 5'd0;
      r_cnt  <= 3'd0;
      r_hold <= 32'h0;
`ifdef REGDUMP_CHECKSUM_EN
      r_csum <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx  <= FIRST_IDX;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum <= 8'h00;
`endif
          end
        end
        S_LOAD: begin
          r_hold <= rd_data;
          r_cnt  <= 3'd0;
        end
        S_SEND: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 3'd1;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum <= r_csum ^ w_byte;
`endif
            if (w_last_byte && !w_last_reg) r_idx <= r_idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// tb/tb_regfile_dump_streamer.sv - scoreboard bench for regfile_dump_streamer (default range and a 3..3 instance).
`timescale 1ns/1ps
module tb_regfile_dump_streamer;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int FR = 1;
  localparam int LR = 29;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        ctrl_reset, start, start_s;
  logic        busy, busy_s;
  logic [4:0]  rd_addr, rd_addr_s;
  logic [31:0] rd_data, rd_data_s;
  logic        out_valid, out_valid_s, out_ready, out_ready_s;
  logic [7:0]  out_data, out_data_s;
  logic        out_last, out_last_s, done, done_s;

  regfile_dump_streamer #(.FIRST_REG(FR), .LAST_REG(LR)) u_dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done));

  regfile_dump_streamer #(.FIRST_REG(3), .LAST_REG(3)) u_single (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start_s), .busy(busy_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_data(out_data_s), .out_last(out_last_s), .done(done_s));

  // Behavioural regfile with a registered read port.
  logic [31:0] regs [32];
  always @(posedge clock) begin
    rd_data   <= regs[rd_addr];
    rd_data_s <= regs[rd_addr_s];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt = 0, done_cnt = 0, done_cyc = 0;
  int hs_s = 0, done_s_cnt = 0, done_s_cyc = 0, last_hs_s_cyc = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected frame from the register contents: per register idx + 4 bytes MSB first, optional XOR trailer.
  function automatic void build(input int f, input int l, input bit sel);
    logic [7:0] x;
    logic [7:0] b [5];
    exp_t       item;
    x = 8'h00;
    for (int i = f; i <= l; i++) begin
      b[0] = 8'(i);
      b[1] = regs[i][31:24];
      b[2] = regs[i][23:16];
      b[3] = regs[i][15:8];
      b[4] = regs[i][7:0];
      for (int k = 0; k < 5; k++) begin
        x      = x ^ b[k];
        item.d = b[k];
        item.l = (CS == 0) && (i == l) && (k == 4);
        if (sel) q1.push_back(item);
        else     q0.push_back(item);
      end
    end
    if (CS != 0) begin
      item.d = x;
      item.l = 1'b1;
      if (sel) q1.push_back(item);
      else     q0.push_back(item);
    end
  endfunction

  logic [7:0] p_data;
  logic       p_last, p_stall = 1'b0, p_done = 1'b0;

  always @(negedge clock) begin
    if (p_stall) begin
      chk("valid_held", out_valid, 1);
      chk("data_held", out_data, p_data);
      chk("last_held", out_last, p_last);
    end
    if (p_done) chk("busy_after_done", busy, 0);
    if (out_valid && out_ready) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte got=%h exp=none", out_data);
      end else begin
        e0 = q0.pop_front();
        chk("byte", out_data, e0.d);
        chk("last", out_last, e0.l);
      end
      hs_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    p_stall = out_valid && !out_ready && !ctrl_reset;
    p_data  = out_data;
    p_last  = out_last;
    p_done  = done && !ctrl_reset;
  end

  always @(negedge clock) begin
    if (out_valid_s && out_ready_s) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL single_unexpected_byte got=%h exp=none", out_data_s);
      end else begin
        e1 = q1.pop_front();
        chk("single_byte", out_data_s, e1.d);
        chk("single_last", out_last_s, e1.l);
      end
      hs_s++;
      last_hs_s_cyc = cyc;
    end
    if (done_s) begin
      done_s_cnt++;
      done_s_cyc = cyc;
    end
  end

  always begin
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic do_start(output int t);
    @(posedge clock); #1;
    start = 1'b1;
    t = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_T1", busy, 1);
    chk("rd_addr_T1", rd_addr, FR);
  endtask

  task automatic wait_done(input int d0, input int max, input string name);
    int k = 0;
    while (done_cnt == d0 && k < max) begin
      @(posedge clock); #1;
      k++;
    end
    if (done_cnt == d0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout got=no_done exp=done", name);
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int t0, d0, h0, k;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    ctrl_reset = 1'b1; start = 1'b0; start_s = 1'b0;
    out_ready = 1'b0; out_ready_s = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    ctrl_reset = 1'b0;

    // Full default frame with ready held high.
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;
    out_ready = 1'b1;
    build(FR, LR, 1'b0);
    d0 = done_cnt;
    do_start(t0);
    wait_done(d0, 400, "frame_a");
    chk("frame_a_done_time", done_cyc - t0, 204 + CS);
    chk("frame_a_drained", q0.size(), 0);

    // 10-cycle stall on r5[31:24], plus an ignored start at T+50.
    build(FR, LR, 1'b0);
    d0 = done_cnt;
    h0 = hs_cnt;
    do_start(t0);
    k = 0;
    while (hs_cnt != h0 + 21 && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    chk("stall_reached", hs_cnt, h0 + 21);
    out_ready = 1'b0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clock);
      chk("stall_data", out_data, regs[5][31:24]);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_cycle(t0 + 50);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(d0, 400, "frame_b");
    chk("frame_b_done_time", done_cyc - t0, 214 + CS);
    repeat (250) @(posedge clock);
    #1;
    chk("frame_b_one_done", done_cnt, d0 + 1);
    chk("frame_b_drained", q0.size(), 0);

    // Reset mid-frame abandons it; a new start dumps from FIRST_REG again.
    build(FR, LR, 1'b0);
    d0 = done_cnt;
    do_start(t0);
    wait_cycle(t0 + 40);
    ctrl_reset = 1'b1;
    @(posedge clock); #1;
    ctrl_reset = 1'b0;
    q0.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    repeat (230) @(posedge clock);
    #1;
    chk("midrst_no_done", done_cnt, d0);
    build(FR, LR, 1'b0);
    do_start(t0);
    wait_done(d0, 400, "frame_c");
    chk("frame_c_drained", q0.size(), 0);

    // Random register contents under random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      build(FR, LR, 1'b0);
      d0 = done_cnt;
      do_start(t0);
      wait_done(d0, 2000, "frame_rand");
      chk("frame_rand_drained", q0.size(), 0);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;

    // Single-register instance.
    regs[3] = 32'hA5A5A5A5;
    build(3, 3, 1'b1);
    d0 = done_s_cnt;
    h0 = hs_s;
    @(posedge clock); #1;
    start_s = 1'b1;
    @(posedge clock); #1;
    start_s = 1'b0;
    k = 0;
    while (done_s_cnt == d0 && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    chk("single_done_seen", done_s_cnt, d0 + 1);
    chk("single_bytes", hs_s - h0, 5 + CS);
    chk("single_done_after_last", done_s_cyc, last_hs_s_cyc + 1);
    chk("single_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
